// File: rtl/trueport_ram_px.sv
// trueport_ram_px: single-clock true dual-port RAM with a power-up clear
// sweep, selectable read-during-write behaviour and optional output register.
//
// Handshake: a request (wren_x / rden_x) is taken at every rising edge where
// rst_n is high and busy is low; there is no backpressure. Each accepted read
// produces exactly one qvalid_x pulse, aligned with the new q_x value.
module trueport_ram_px #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wren_a,
  input  logic                  rden_a,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic                  qvalid_a,
  input  logic                  wren_b,
  input  logic                  rden_b,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  qvalid_b,
  output logic                  busy,
  output logic                  collision
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } init_state_t;

  init_state_t           state;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Qualified requests: nothing is accepted during reset or the clear sweep.
  logic we_a, we_b, re_a, re_b, clr_we, same_addr;

  assign we_a      = rst_n & ~busy & wren_a;
  assign we_b      = rst_n & ~busy & wren_b;
  assign re_a      = rst_n & ~busy & rden_a;
  assign re_b      = rst_n & ~busy & rden_b;
  assign clr_we    = rst_n & (state == CLEAR);
  assign same_addr = (address_a == address_b);

  // Init FSM: sweep every word to zero once after reset, then serve requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY:   state <= READY;
        default: state <= CLEAR;
      endcase
    end
  end

  // Memory array: clear sweep, otherwise both ports with port A winning a tie.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (we_b && !(we_a && same_addr)) mem[address_b] <= data_b;
      if (we_a)                         mem[address_a] <= data_a;
    end
  end

  // Read data selection; in new-data mode a same-cycle write is forwarded,
  // and when both ports write the same word the port A value is what lands.
  logic [DATA_WIDTH-1:0] rd_val_a, rd_val_b;

  always_comb begin
    rd_val_a = mem[address_a];
    rd_val_b = mem[address_b];
    if (RDW_MODE != 0) begin
      if (we_a)                   rd_val_a = data_a;
      else if (we_b && same_addr) rd_val_a = data_b;
      if (we_a && same_addr)      rd_val_b = data_a;
      else if (we_b)              rd_val_b = data_b;
    end
  end

  logic [DATA_WIDTH-1:0] q1_a, q1_b;
  logic                  v1_a, v1_b;

  // First read stage and the collision flag; q holds between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1_a      <= '0;
      q1_b      <= '0;
      v1_a      <= 1'b0;
      v1_b      <= 1'b0;
      collision <= 1'b0;
    end else begin
      v1_a      <= re_a;
      v1_b      <= re_b;
      collision <= we_a & we_b & same_addr;
      if (re_a) q1_a <= rd_val_a;
      if (re_b) q1_b <= rd_val_b;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q2_a, q2_b;
      logic                  v2_a, v2_b;

      // Optional second stage: advances only on a valid first-stage result.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q2_a <= '0;
          q2_b <= '0;
          v2_a <= 1'b0;
          v2_b <= 1'b0;
        end else begin
          v2_a <= v1_a;
          v2_b <= v1_b;
          if (v1_a) q2_a <= q1_a;
          if (v1_b) q2_b <= q1_b;
        end
      end

      assign q_a      = q2_a;
      assign q_b      = q2_b;
      assign qvalid_a = v2_a;
      assign qvalid_b = v2_b;
    end else begin : g_no_out_reg
      assign q_a      = q1_a;
      assign q_b      = q1_b;
      assign qvalid_a = v1_a;
      assign qvalid_b = v1_b;
    end
  endgenerate

endmodule

// File: tb/tb_trueport_ram_px.sv
// tb_trueport_ram_px: drives one stimulus stream into two instances
// (defaults, and 32x16 new-data with output register) and compares both
// against a per-instance behavioural model of the RAM.
module tb_trueport_ram_px;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        wren_a = 1'b0, rden_a = 1'b0, wren_b = 1'b0, rden_b = 1'b0;
  logic [8:0]  address_a = '0, address_b = '0;
  logic [31:0] data_a = '0, data_b = '0;

  logic [7:0]  q_a0, q_b0;
  logic        qvalid_a0, qvalid_b0, busy0, collision0;
  logic [31:0] q_a1, q_b1;
  logic        qvalid_a1, qvalid_b1, busy1, collision1;

  trueport_ram_px dut0 (
    .clk(clk), .rst_n(rst_n),
    .wren_a(wren_a), .rden_a(rden_a), .address_a(address_a), .data_a(data_a[7:0]),
    .q_a(q_a0), .qvalid_a(qvalid_a0),
    .wren_b(wren_b), .rden_b(rden_b), .address_b(address_b), .data_b(data_b[7:0]),
    .q_b(q_b0), .qvalid_b(qvalid_b0),
    .busy(busy0), .collision(collision0)
  );

  trueport_ram_px #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .wren_a(wren_a), .rden_a(rden_a), .address_a(address_a[3:0]), .data_a(data_a),
    .q_a(q_a1), .qvalid_a(qvalid_a1),
    .wren_b(wren_b), .rden_b(rden_b), .address_b(address_b[3:0]), .data_b(data_b),
    .q_b(q_b1), .qvalid_b(qvalid_b1),
    .busy(busy1), .collision(collision1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_depth [2] = '{512, 16};
  int          m_lat   [2] = '{0, 1};
  int          m_rdw   [2] = '{0, 1};
  logic [63:0] m_dmask [2] = '{64'hFF, 64'hFFFF_FFFF};

  logic [63:0] m_mem [2][512];
  bit          m_busy [2];
  int          m_cnt  [2];
  logic [63:0] m_q_a [2], m_q_b [2], m_pd_a [2], m_pd_b [2];
  bit          m_qv_a [2], m_qv_b [2], m_pv_a [2], m_pv_b [2], m_coll [2];

  // What a reader of word x sees given this cycle's writes.
  function automatic logic [63:0] read_word(int i, int x, bit wa, int aa, logic [63:0] da,
                                            bit wb, int ab, logic [63:0] db);
    if (m_rdw[i] != 0 && wa && aa == x) return da;
    if (m_rdw[i] != 0 && wb && ab == x) return db;
    return m_mem[i][x];
  endfunction

  task automatic model_edge(input int i);
    int aa, ab;
    logic [63:0] da, db, va, vb;
    bit wa, wb, ra, rb;
    aa = int'(address_a) % m_depth[i];
    ab = int'(address_b) % m_depth[i];
    da = 64'(data_a) & m_dmask[i];
    db = 64'(data_b) & m_dmask[i];
    if (!rst_n) begin
      m_busy[i] = 1; m_cnt[i] = 0; m_coll[i] = 0;
      m_q_a[i] = 0; m_q_b[i] = 0; m_qv_a[i] = 0; m_qv_b[i] = 0;
      m_pd_a[i] = 0; m_pd_b[i] = 0; m_pv_a[i] = 0; m_pv_b[i] = 0;
      return;
    end
    if (m_busy[i]) begin
      wa = 0; wb = 0; ra = 0; rb = 0;
      m_cnt[i]++;
      if (m_cnt[i] == m_depth[i]) begin
        m_busy[i] = 0;
        for (int j = 0; j < 512; j++) m_mem[i][j] = 0;
      end
    end else begin
      wa = wren_a; wb = wren_b; ra = rden_a; rb = rden_b;
    end
    va = read_word(i, aa, wa, aa, da, wb, ab, db);
    vb = read_word(i, ab, wa, aa, da, wb, ab, db);
    m_coll[i] = wa && wb && (aa == ab);
    if (wb) m_mem[i][ab] = db;
    if (wa) m_mem[i][aa] = da;  // port A applied last, so it wins a tie
    if (m_lat[i] == 0) begin
      m_qv_a[i] = ra; if (ra) m_q_a[i] = va;
      m_qv_b[i] = rb; if (rb) m_q_b[i] = vb;
    end else begin
      m_qv_a[i] = m_pv_a[i]; if (m_pv_a[i]) m_q_a[i] = m_pd_a[i];
      m_qv_b[i] = m_pv_b[i]; if (m_pv_b[i]) m_q_b[i] = m_pd_b[i];
      m_pv_a[i] = ra; if (ra) m_pd_a[i] = va;
      m_pv_b[i] = rb; if (rb) m_pd_b[i] = vb;
    end
  endtask

  task automatic check_all();
    check("q_a0",       64'(q_a0),       m_q_a[0]);
    check("qvalid_a0",  64'(qvalid_a0),  64'(m_qv_a[0]));
    check("q_b0",       64'(q_b0),       m_q_b[0]);
    check("qvalid_b0",  64'(qvalid_b0),  64'(m_qv_b[0]));
    check("busy0",      64'(busy0),      64'(m_busy[0]));
    check("collision0", 64'(collision0), 64'(m_coll[0]));
    check("q_a1",       64'(q_a1),       m_q_a[1]);
    check("qvalid_a1",  64'(qvalid_a1),  64'(m_qv_a[1]));
    check("q_b1",       64'(q_b1),       m_q_b[1]);
    check("qvalid_b1",  64'(qvalid_b1),  64'(m_qv_b[1]));
    check("busy1",      64'(busy1),      64'(m_busy[1]));
    check("collision1", 64'(collision1), 64'(m_coll[1]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all();
  endtask

  task automatic op(input bit wa, input bit ra, input int aa, input logic [31:0] da,
                    input bit wb, input bit rb, input int ab, input logic [31:0] db);
    wren_a = wa; rden_a = ra; address_a = 9'(aa); data_a = da;
    wren_b = wb; rden_b = rb; address_b = 9'(ab); data_b = db;
    tick();
  endtask

  task automatic idle();
    op(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rand_addr();
    case ($urandom_range(0, 3))
      0:       return 'h1FF;
      1:       return 'h020;
      2:       return int'($urandom_range(0, 15));
      default: return int'($urandom_range(0, 511));
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;

    // Reset two cycles, then measure the clear sweep.
    rst_n = 1'b0;
    idle();
    idle();
    rst_n = 1'b1;
    n = 0;
    do begin idle(); n++; end while (busy0 && n < 1000);
    check("busy_len", 64'(n), 64'd512);

    // Fresh memory reads as zero at the ends and the middle.
    foreach (m_depth[k]) begin end
    for (int k = 0; k < 3; k++) begin
      int a;
      a = (k == 0) ? 0 : (k == 1) ? 255 : 511;
      op(0, 1, a, 0, 0, 1, a, 0);
      check("clr_read_q", 64'(q_a0), 64'h0);
      check("clr_read_v", 64'(qvalid_a0), 64'h1);
    end
    idle();

    // Write on A, read back on B.
    op(1, 0, 'h010, 32'hA5, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0, 1, 'h010, 0);
    check("xport_read", 64'(q_b0), 64'hA5);

    // Cross-port read during write: old data on the default instance.
    op(1, 0, 'h020, 32'h11, 0, 0, 0, 0);
    op(1, 0, 'h020, 32'h3C, 0, 1, 'h020, 0);
    check("rdw_old", 64'(q_b0), 64'h11);
    idle();

    // Same-address double write: A wins, collision pulses once.
    op(1, 0, 'h1FF, 32'h55, 1, 0, 'h1FF, 32'hAA);
    check("coll_pulse", 64'(collision0), 64'h1);
    idle();
    check("coll_clear", 64'(collision0), 64'h0);
    op(0, 0, 0, 0, 0, 1, 'h1FF, 0);
    check("coll_winner", 64'(q_b0), 64'h55);
    idle();

    // Back-to-back writes then back-to-back reads on both ports.
    for (int i = 0; i < 16; i++)
      op(1, 0, i, $urandom, 1, 0, 256 + ((i + 8) % 16), $urandom);
    for (int i = 0; i < 16; i++) begin
      op(0, 1, i, 0, 0, 1, 256 + i, 0);
      if (i >= 1) check("b2b_qvalid1", 64'(qvalid_a1), 64'h1);
    end
    idle();
    idle();

    // Randomized traffic concentrated on a few hot addresses.
    repeat (2000) begin
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom,
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end
    idle();
    idle();

    // Reset partway through a sweep restarts it; writes during busy are dropped.
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    repeat (100) idle();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    n = 0;
    do begin op(1, 0, 'h033, 32'hFF, 0, 0, 0, 0); n++; end while (busy0 && n < 1000);
    check("busy_len_restart", 64'(n), 64'd512);
    op(0, 1, 'h033, 0, 0, 0, 0, 0);
    check("busy_write_dropped", 64'(q_a0), 64'h0);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trueport_ram_px.md
TRUEPORT_RAM_PX -- requirements
Module: trueport_ram_px

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits (1..64).
REQ-002 Parameter ADDR_WIDTH, default 9, address width; DEPTH = 2^ADDR_WIDTH words.
REQ-003 Parameter RDW_MODE, default 0, read-during-write result: 0 = old data, 1 = new data.
REQ-004 Parameter OUT_REG, default 0, 1 = one extra output register stage on both ports.
REQ-005 clk  input  1  single clock for both ports; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 wren_a, rden_a  input  1 each  port A write / read request.
REQ-008 address_a  input  ADDR_WIDTH  port A address.
REQ-009 data_a  input  DATA_WIDTH  port A write data.
REQ-010 q_a  output  DATA_WIDTH  port A read data, registered.
REQ-011 qvalid_a  output  1  one-cycle pulse marking new q_a data.
REQ-012 wren_b, rden_b, address_b, data_b, q_b, qvalid_b: port B, same widths and meanings as port A.
REQ-013 busy  output  1  high while memory-clear sweep runs; requests ignored.
REQ-014 collision  output  1  registered one-cycle pulse: both ports wrote the same address in the same cycle.

Function
REQ-015 Init FSM states: CLEAR, READY; rst_n low at an edge forces CLEAR with sweep counter = 0.
REQ-016 CLEAR: each cycle with rst_n high writes 0 to ram[counter], counter increments; after writing DEPTH-1, next state READY.
REQ-017 busy = 1 in CLEAR, 0 in READY; clear takes exactly DEPTH cycles after first edge with rst_n high.
REQ-018 rst_n low during CLEAR restarts the sweep from address 0; no partial-state carry-over.
REQ-019 While busy, wren/rden on both ports are ignored: no write, no read, qvalid stays 0.
REQ-020 READY, wren_x high at edge N: ram[address_x] <= data_x at edge N.
REQ-021 READY, rden_x high at edge N: q_x updated at edge N (OUT_REG=0) or N+1 (OUT_REG=1); qvalid_x high for exactly that one cycle.
REQ-022 rden_x low: q_x holds last read value; no qvalid pulse.
REQ-023 Back-to-back reads every cycle: one result per cycle, in order, no bubbles.
REQ-024 Read and write to same address in same cycle (same port or cross-port): q = pre-write contents if RDW_MODE=0, written data if RDW_MODE=1.
REQ-025 Both ports write same address same cycle: port A data stored, port B write dropped; collision = 1 for the following cycle.
REQ-026 Reads from both ports, same or different address, same cycle: both served, no conflict.
REQ-027 Cross-port RDW with both ports writing same address, RDW_MODE=1: readers see port A data.
REQ-028 Addresses span full 2^ADDR_WIDTH range; no out-of-range case exists.

Reset
REQ-029 rst_n low at an edge: q_a = q_b = 0, qvalid_a = qvalid_b = 0, collision = 0, busy = 1, output pipeline registers = 0.
REQ-030 After clear completes, every RAM word reads 0.

Verification
REQ-031 Defaults, rst_n low 2 cycles then high: busy high exactly 512 cycles; then read addr 0, 255, 511 -> q = 8'h00, qvalid one pulse each.
REQ-032 Port A write 8'hA5 to addr 9'h010, next cycle port B read 9'h010 -> q_b = 8'hA5 one cycle later (two with OUT_REG=1).
REQ-033 Same cycle: A writes 8'h3C to 9'h020 (old 8'h11), B reads 9'h020 -> q_b = 8'h11 (RDW_MODE=0), 8'h3C (RDW_MODE=1).
REQ-034 Same cycle: A writes 8'h55, B writes 8'hAA, both to 9'h1FF -> collision pulse next cycle; later read returns 8'h55.
REQ-035 rst_n low at sweep counter 100, then high -> busy high another full 512 cycles; wren_a asserted during busy leaves target at 0.
REQ-036 DATA_WIDTH=32, ADDR_WIDTH=4, OUT_REG=1: 16 back-to-back writes then reads on both ports -> data matches, 2-cycle latency, continuous qvalid.
